// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Sequences one req/ack memory transaction per MEM-stage load/store and
// produces the pipeline stall that holds the EX/MEM register (and everything
// upstream) until the access has completed or been abandoned on timeout.
// Also keeps the last load data for MEM/WB, a sticky error flag and a
// saturating count of memory-induced stall cycles for debug.
module dmem_access_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              Memory_read_i,
    input  logic              Memory_write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              ext_stall_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o,
    output logic [31:0]       stall_cnt_o
);

    // The timeout counter holds the number of REQ cycles already spent
    // without ack; the cycle in which it equals TIMEOUT_CYC-1 is the last
    // one allowed, so an ack-less edge there ends the transaction.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        access;
    logic        both_ctrl;
    logic        tmo_hit;
    logic        mem_stall;
    logic [15:0] tmo_cnt;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign access    = Memory_read_i | Memory_write_i;
    assign both_ctrl = Memory_read_i & Memory_write_i;
    assign tmo_hit   = (tmo_cnt == TMO_LAST);

    // State register; reset aborts any outstanding transaction at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. DONE waits for the pipeline to actually advance
    // (ext_stall_i low) so the same instruction is never issued twice.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (access) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_ack_i || tmo_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!ext_stall_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State-decoded outputs: request strobe and the memory share of the stall.
    always_comb begin
        mem_req_o = 1'b0;
        mem_stall = 1'b0;
        unique case (state)
            IDLE: begin
                mem_stall = access;
            end
            REQ: begin
                mem_req_o = 1'b1;
                mem_stall = 1'b1;
            end
            DONE: begin
                mem_req_o = 1'b0;
                mem_stall = 1'b0;
            end
            default: begin
                mem_req_o = 1'b0;
                mem_stall = 1'b0;
            end
        endcase
    end

    assign stall_o = ext_stall_i | mem_stall;

    // Capture the access in IDLE so address/data/direction stay frozen in REQ.
    // A simultaneous load+store is resolved as a store.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_we_o    <= 1'b0;
        end else if (state == IDLE && access) begin
            mem_addr_o  <= addr_i;
            mem_wdata_o <= wdata_i;
            mem_we_o    <= Memory_write_i;
        end
    end

    // Count ack-less REQ cycles; cleared whenever REQ is not continuing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt <= '0;
        end else if (state == REQ && !mem_ack_i && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    // Load data is taken only from a real ack to a read; acks seen outside
    // REQ are spurious and dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else if (state == REQ && mem_ack_i && !mem_we_o) begin
            rdata_o <= mem_rdata_i;
        end
    end

    // Sticky error: conflicting controls at issue, or a timed-out request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if ((state == IDLE && both_ctrl) ||
                     (state == REQ && !mem_ack_i && tmo_hit)) begin
            err_o <= 1'b1;
        end
    end

    // Saturating count of cycles stalled because of the memory access.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (mem_stall) begin
            stall_cnt_o <= sat_inc(stall_cnt_o);
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl (built with a 4-cycle timeout).
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
module tb_dmem_access_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              Memory_read_i;
    logic              Memory_write_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              ext_stall_i;
    logic              stall_o;
    logic [DATA_W-1:0] rdata_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              err_o;
    logic [31:0]       stall_cnt_o;

    int errors = 0;
    int checks = 0;

    dmem_access_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .Memory_read_i (Memory_read_i),
        .Memory_write_i(Memory_write_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .ext_stall_i   (ext_stall_i),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i),
        .err_o         (err_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        Memory_read_i = 1'b0;
        Memory_write_i = 1'b0;
        addr_i = '0;
        wdata_i = '0;
        ext_stall_i = 1'b0;
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        tick();
        tick();
        #1;
        check("rst_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_we", {31'd0, mem_we_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_cnt", stall_cnt_o, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        rst_i = 1'b0;

        // Load at 0x40, ack on the third REQ cycle
        tick();
        Memory_read_i = 1'b1; addr_i = 32'h40;
        #1;
        check("A_detect_stall", {31'd0, stall_o}, 32'd1);
        check("A_detect_req", {31'd0, mem_req_o}, 32'd0);
        tick(); #1;
        check("A_req1", {31'd0, mem_req_o}, 32'd1);
        check("A_we", {31'd0, mem_we_o}, 32'd0);
        check("A_addr", mem_addr_o, 32'h40);
        check("A_stall1", {31'd0, stall_o}, 32'd1);
        tick(); #1;
        check("A_req2", {31'd0, mem_req_o}, 32'd1);
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        #1;
        check("A_req3", {31'd0, mem_req_o}, 32'd1);
        check("A_stall3", {31'd0, stall_o}, 32'd1);
        tick();
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        #1;
        check("A_done_req", {31'd0, mem_req_o}, 32'd0);
        check("A_done_stall", {31'd0, stall_o}, 32'd0);
        check("A_rdata", rdata_o, 32'hDEADBEEF);
        check("A_cnt", stall_cnt_o, 32'd4);
        check("A_err", {31'd0, err_o}, 32'd0);
        tick();
        Memory_read_i = 1'b0;
        #1;
        check("A_idle_stall", {31'd0, stall_o}, 32'd0);
        check("A_idle_cnt", stall_cnt_o, 32'd4);

        // Store at 0x80 with same-cycle ack
        Memory_write_i = 1'b1; addr_i = 32'h80; wdata_i = 32'h12345678;
        #1;
        check("B_detect_stall", {31'd0, stall_o}, 32'd1);
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0BAD0BAD;
        #1;
        check("B_req", {31'd0, mem_req_o}, 32'd1);
        check("B_we", {31'd0, mem_we_o}, 32'd1);
        check("B_wdata", mem_wdata_o, 32'h12345678);
        check("B_addr", mem_addr_o, 32'h80);
        tick();
        mem_ack_i = 1'b0;
        #1;
        check("B_done_req", {31'd0, mem_req_o}, 32'd0);
        check("B_done_stall", {31'd0, stall_o}, 32'd0);
        check("B_rdata_kept", rdata_o, 32'hDEADBEEF);
        check("B_cnt", stall_cnt_o, 32'd6);
        tick();
        Memory_write_i = 1'b0;

        // Load at 0x44, ack at once, external stall holds DONE for 2 cycles
        Memory_read_i = 1'b1; addr_i = 32'h44;
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
        tick();
        mem_ack_i = 1'b0; ext_stall_i = 1'b1;
        #1;
        check("C_done_stall_ext", {31'd0, stall_o}, 32'd1);
        check("C_done_req", {31'd0, mem_req_o}, 32'd0);
        check("C_cnt_a", stall_cnt_o, 32'd8);
        tick(); #1;
        check("C_hold1_req", {31'd0, mem_req_o}, 32'd0);
        check("C_hold1_cnt", stall_cnt_o, 32'd8);
        tick(); #1;
        check("C_hold2_req", {31'd0, mem_req_o}, 32'd0);
        check("C_hold2_cnt", stall_cnt_o, 32'd8);
        ext_stall_i = 1'b0;
        #1;
        check("C_release_stall", {31'd0, stall_o}, 32'd0);
        tick();
        Memory_read_i = 1'b0;
        #1;
        check("C_rdata", rdata_o, 32'hCAFEF00D);
        check("C_idle_req", {31'd0, mem_req_o}, 32'd0);

        // Spurious ack in IDLE
        mem_ack_i = 1'b1; mem_rdata_i = 32'h55555555;
        tick();
        mem_ack_i = 1'b0;
        #1;
        check("S_rdata", rdata_o, 32'hCAFEF00D);
        check("S_req", {31'd0, mem_req_o}, 32'd0);
        check("S_cnt", stall_cnt_o, 32'd8);

        // Timeout: load at 0x48, never acked
        Memory_read_i = 1'b1; addr_i = 32'h48;
        tick(); #1;
        check("D_req1", {31'd0, mem_req_o}, 32'd1);
        tick(); #1;
        check("D_req2", {31'd0, mem_req_o}, 32'd1);
        tick(); #1;
        check("D_req3", {31'd0, mem_req_o}, 32'd1);
        tick(); #1;
        check("D_req4", {31'd0, mem_req_o}, 32'd1);
        check("D_err_pre", {31'd0, err_o}, 32'd0);
        tick(); #1;
        check("D_req_drop", {31'd0, mem_req_o}, 32'd0);
        check("D_err", {31'd0, err_o}, 32'd1);
        check("D_stall_rel", {31'd0, stall_o}, 32'd0);
        check("D_rdata", rdata_o, 32'hCAFEF00D);
        check("D_cnt", stall_cnt_o, 32'd13);
        tick();
        Memory_read_i = 1'b0;
        #1;
        check("D_err_sticky", {31'd0, err_o}, 32'd1);

        // Asynchronous reset in the middle of REQ
        Memory_read_i = 1'b1; addr_i = 32'h4C;
        tick(); #1;
        check("F_req", {31'd0, mem_req_o}, 32'd1);
        #2;
        rst_i = 1'b1; Memory_read_i = 1'b0;
        #1;
        check("F_req", {31'd0, mem_req_o}, 32'd0);
        check("F_stall", {31'd0, stall_o}, 32'd0);
        check("F_err", {31'd0, err_o}, 32'd0);
        check("F_cnt", stall_cnt_o, 32'd0);
        check("F_rdata", rdata_o, 32'd0);
        check("F_addr", mem_addr_o, 32'd0);
        ext_stall_i = 1'b1;
        #1;
        check("F_stall_ext", {31'd0, stall_o}, 32'd1);
        ext_stall_i = 1'b0;
        tick();
        rst_i = 1'b0;

        // Load and store together: store wins and err is flagged
        Memory_read_i = 1'b1; Memory_write_i = 1'b1;
        addr_i = 32'h90; wdata_i = 32'hA5A5A5A5;
        #1;
        check("E_err_pre", {31'd0, err_o}, 32'd0);
        check("E_stall", {31'd0, stall_o}, 32'd1);
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h77777777;
        #1;
        check("E_we", {31'd0, mem_we_o}, 32'd1);
        check("E_err", {31'd0, err_o}, 32'd1);
        check("E_addr", mem_addr_o, 32'h90);
        check("E_wdata", mem_wdata_o, 32'hA5A5A5A5);
        tick();
        mem_ack_i = 1'b0;
        #1;
        check("E_rdata", rdata_o, 32'd0);
        check("E_cnt", stall_cnt_o, 32'd2);
        tick();
        Memory_read_i = 1'b0; Memory_write_i = 1'b0;
        #1;
        check("E_err_sticky", {31'd0, err_o}, 32'd1);
        check("E_idle_stall", {31'd0, stall_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: simulation bound reached");
        $fatal(1, "bench time limit");
    end

endmodule
